alu_seq: RTL and testbench

//  Parametrised successor to the 8-bit ALU: WIDTH-bit ALU with valid/ready handshakes, registered result and flags.

---
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq - WIDTH-bit sequential ALU with valid/ready handshakes.
//
// Accepts one operation per cycle when idle and the output slot is free
// (or being retired in the same cycle). Single-cycle ops register their
// result at the accept edge; MUL/MULH run an iterative shift-add multiplier
// for WIDTH cycles before loading the result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   a/b/op/cin carry a valid operation
//   in_ready   block can accept an operation this cycle
//   a, b       operands (shift amount = b[SHW-1:0])
//   op         opcode (ADD ADC SUB SBC AND OR XOR NOT SHL SHR ASR ROL ROR MUL MULH CMP)
//   cin        carry in for ADC/SBC
//   out_valid  out/flags hold a result
//   out_ready  consumer takes the result this cycle
//   out        result
//   flags      {N,Z,C,V}
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_ADD  = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8, OP_SHR = 4'h9, OP_ASR = 4'hA, OP_ROL = 4'hB;
  localparam logic [3:0] OP_ROR  = 4'hC, OP_MUL = 4'hD, OP_MULH = 4'hE, OP_CMP = 4'hF;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t state, state_next;

  logic accept, retire, is_mul_op, last_step;
  logic [SHW-1:0] count;

  logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_step;
  logic [WIDTH-1:0]   mul_mplier, mul_res;
  logic               mul_high;
  logic [3:0]         mul_flags;

  logic             sub_op, carry_in;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum, shl_w, shr_w, asr_w;
  logic             arith_v;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     rsh;
  logic [WIDTH-1:0] rol_v, ror_v;

  logic [WIDTH-1:0] alu_res, flag_src;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  assign in_ready  = (state == ST_IDLE) & (~out_valid | out_ready) & ~rst;
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign is_mul_op = (op == OP_MUL) | (op == OP_MULH);
  assign last_step = (count == SHW'(WIDTH - 1));

  // Subtraction is a + ~b + carry, so C=1 means no borrow.
  assign sub_op   = (op == OP_SUB) | (op == OP_SBC) | (op == OP_CMP);
  assign b_eff    = sub_op ? ~b : b;
  assign carry_in = (op == OP_ADD) ? 1'b0 :
                    ((op == OP_SUB) | (op == OP_CMP)) ? 1'b1 : cin;
  assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
  assign arith_v  = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

  // Shifts carry one extra bit so the last bit shifted out lands in it;
  // with a zero amount that extra bit is the zero padding, giving C=0.
  assign sh    = b[SHW-1:0];
  assign rsh   = (SHW+1)'(WIDTH) - {1'b0, sh};
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;
  assign asr_w = $unsigned($signed({a, 1'b0}) >>> sh);
  assign rol_v = (a << sh) | (a >> rsh);
  assign ror_v = (a >> sh) | (a << rsh);

  // Multiplier datapath: one conditional add of the shifted multiplicand per cycle.
  assign mul_step  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_res   = mul_high ? mul_step[2*WIDTH-1:WIDTH] : mul_step[WIDTH-1:0];
  assign mul_flags = {mul_res[WIDTH-1], mul_res == '0, |mul_step[2*WIDTH-1:WIDTH], 1'b0};

  // Single-cycle result and flags; CMP passes a through but flags the difference.
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = arith_v;
      end
      OP_CMP: begin
        alu_res = a;
        alu_c   = sum[WIDTH];
        alu_v   = arith_v;
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin alu_res = shl_w[WIDTH-1:0]; alu_c = shl_w[WIDTH]; end
      OP_SHR: begin alu_res = shr_w[WIDTH:1];   alu_c = shr_w[0];     end
      OP_ASR: begin alu_res = asr_w[WIDTH:1];   alu_c = asr_w[0];     end
      OP_ROL: begin alu_res = rol_v; alu_c = (sh != '0) & rol_v[0];       end
      OP_ROR: begin alu_res = ror_v; alu_c = (sh != '0) & ror_v[WIDTH-1]; end
      default: alu_res = '0;
    endcase
    flag_src  = (op == OP_CMP) ? sum[WIDTH-1:0] : alu_res;
    alu_flags = {flag_src[WIDTH-1], flag_src == '0, alu_c, alu_v};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state: multiplies leave IDLE for WIDTH cycles.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && is_mul_op) state_next = ST_MUL;
      ST_MUL:  if (last_step) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Result register, handshake and multiplier registers. A retire clears
  // out_valid unless a new result loads at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out        <= '0;
      flags      <= '0;
      count      <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_high   <= 1'b0;
    end else begin
      if (retire) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul_op) begin
              count      <= '0;
              mul_acc    <= '0;
              mul_mcand  <= {{WIDTH{1'b0}}, a};
              mul_mplier <= b;
              mul_high   <= (op == OP_MULH);
            end else begin
              out       <= alu_res;
              flags     <= alu_flags;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          mul_acc    <= mul_step;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          count      <= count + SHW'(1);
          if (last_step) begin
            out       <= mul_res;
            flags     <= mul_flags;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq - self-checking bench for alu_seq (WIDTH=8).
// Expected results are computed by a behavioural model when an operation is
// accepted, queued, and compared when the DUT retires a result.
module tb_alu_seq;

   localparam int WIDTH = 8;

   localparam logic [3:0] ADD = 4'h0, ADC = 4'h1, SUB = 4'h2, SBC = 4'h3;
   localparam logic [3:0] AND_ = 4'h4, OR_ = 4'h5, XOR_ = 4'h6, NOT_ = 4'h7;
   localparam logic [3:0] SHL = 4'h8, SHR = 4'h9, ASR = 4'hA, ROL = 4'hB;
   localparam logic [3:0] ROR = 4'hC, MUL = 4'hD, MULH = 4'hE, CMP = 4'hF;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, cin, out_valid, out_ready;
   logic [WIDTH-1:0] a, b, out;
   logic [3:0] op, flags;

   int checkCount = 0;
   int passCount = 0;
   int cycleCount = 0;
   bit randReady = 1'b0;
   logic [11:0] expQ[$];
   logic [11:0] monExp;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready), .out(out), .flags(flags)
   );

   // Free-running clock and cycle counter used for throughput measurement
   always #5 clk = ~clk;
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
   endtask

   // Behavioural reference: returns {N,Z,C,V, out}
   function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic [3:0] o, input logic ci);
      logic [8:0] s;
      logic [7:0] r, nzv;
      logic c, v;
      logic [15:0] p;
      s = '0; r = '0; c = 1'b0; v = 1'b0; p = '0;
      case (o)
         ADD, ADC: begin
            s = x + y + ((o == ADC) ? 9'(ci) : 9'd0);
            r = s[7:0]; c = s[8];
            v = (x[7] == y[7]) && (r[7] != x[7]);
         end
         SUB, SBC, CMP: begin
            s = x + (8'hFF ^ y) + ((o == SBC) ? 9'(ci) : 9'd1);
            r = s[7:0]; c = s[8];
            v = (x[7] != y[7]) && (r[7] != x[7]);
         end
         AND_: r = x & y;
         OR_:  r = x | y;
         XOR_: r = x ^ y;
         NOT_: r = ~x;
         MUL, MULH: begin
            p = 16'(x) * 16'(y);
            r = (o == MUL) ? p[7:0] : p[15:8];
            c = (p[15:8] != 8'h00);
         end
         default: begin
            r = x;
            for (int i = 0; i < int'(y[2:0]); i++) begin
               case (o)
                  SHL: begin c = r[7]; r = {r[6:0], 1'b0}; end
                  SHR: begin c = r[0]; r = {1'b0, r[7:1]}; end
                  ASR: begin c = r[0]; r = {r[7], r[7:1]}; end
                  ROL: begin c = r[7]; r = {r[6:0], r[7]}; end
                  default: begin c = r[0]; r = {r[0], r[7:1]}; end
               endcase
            end
         end
      endcase
      nzv = r;
      if (o == CMP) begin
         nzv = s[7:0];
         r = x;
      end
      return {nzv[7], (nzv == 8'h00), c, v, r};
   endfunction

   // Scoreboard: every retired result is compared against the oldest expectation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected result", 32'd1, 32'd0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("result out", 32'(out), 32'(monExp[7:0]));
            checkOutput("result flags", 32'(flags), 32'(monExp[11:8]));
         end
      end
   end

   // Drive one operation, hold it until accepted, then scramble the operands.
   // Returns #1 after the accept edge so calls can follow back-to-back.
   task automatic applyStimulus(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input logic c);
      int waitCycles = 0;
      bit done = 1'b0;
      op = o; a = x; b = y; cin = c; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            expQ.push_back(model(x, y, o, c));
            done = 1'b1;
         end else if (++waitCycles > 50) begin
            checkOutput("accept timeout", 32'd0, 32'd1);
            done = 1'b1;
         end
         @(posedge clk); #1;
         if (randReady) out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
   endtask

   // Let all outstanding results retire, bounded
   task automatic waitDrain();
      int n = 0;
      out_ready = 1'b1;
      while (expQ.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      checkOutput("drain", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      int lowCycles;
      int stable;
      int readyLow;
      int startCycle;
      int spurious;
      logic [7:0] heldOut;
      logic [3:0] heldFlags;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset out", 32'(out), 32'd0);
      checkOutput("reset flags", 32'(flags), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed vectors, including carry/overflow and shift-amount boundaries
      applyStimulus(ADD, 8'hFF, 8'h01, 1'b0);
      checkOutput("add latency", 32'(out_valid), 32'd1);
      applyStimulus(SUB, 8'h80, 8'h01, 1'b0);
      applyStimulus(SBC, 8'h00, 8'h00, 1'b0);
      applyStimulus(SBC, 8'h05, 8'h03, 1'b1);
      applyStimulus(ADC, 8'h7F, 8'h00, 1'b1);
      applyStimulus(CMP, 8'h85, 8'h03, 1'b0);
      applyStimulus(ROR, 8'h01, 8'h01, 1'b0);
      applyStimulus(ASR, 8'h80, 8'h03, 1'b0);
      applyStimulus(SHL, 8'h5A, 8'h08, 1'b0);
      applyStimulus(SHR, 8'h81, 8'h01, 1'b0);
      applyStimulus(ROL, 8'h81, 8'h0B, 1'b0);
      applyStimulus(AND_, 8'hF0, 8'h3C, 1'b1);
      applyStimulus(OR_, 8'h00, 8'h00, 1'b1);
      applyStimulus(XOR_, 8'hAA, 8'hFF, 1'b0);
      applyStimulus(NOT_, 8'h0F, 8'h00, 1'b0);

      // Multiply: in_ready stays low for WIDTH cycles before the result appears
      applyStimulus(MUL, 8'h10, 8'h10, 1'b0);
      lowCycles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
         if (!in_ready) lowCycles++;
      end
      checkOutput("mul busy cycles", 32'(lowCycles), 32'd8);
      @(posedge clk); #1;
      applyStimulus(MULH, 8'h10, 8'h10, 1'b0);
      applyStimulus(MUL, 8'hFF, 8'hFF, 1'b0);
      applyStimulus(MULH, 8'hFF, 8'hFF, 1'b0);
      waitDrain();

      // Random operations with random consumer backpressure
      randReady = 1'b1;
      for (int i = 0; i < 40; i++)
         applyStimulus(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      randReady = 1'b0;
      waitDrain();

      // Backpressure: held result must stay stable and block new inputs
      out_ready = 1'b0;
      applyStimulus(ADD, 8'h12, 8'h34, 1'b0);
      @(negedge clk);
      heldOut = out;
      heldFlags = flags;
      stable = 0;
      readyLow = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid && out == heldOut && flags == heldFlags) stable++;
         if (!in_ready) readyLow++;
      end
      checkOutput("backpressure stable", 32'(stable), 32'd5);
      checkOutput("backpressure in_ready low", 32'(readyLow), 32'd5);
      @(posedge clk); #1;
      out_ready = 1'b1;
      startCycle = cycleCount;
      applyStimulus(ADD, 8'h01, 8'h02, 1'b0);
      applyStimulus(ADD, 8'h7F, 8'h7F, 1'b0);
      applyStimulus(ADD, 8'h80, 8'h80, 1'b1);
      applyStimulus(ADD, 8'hC3, 8'h3D, 1'b0);
      checkOutput("back-to-back cycles", 32'(cycleCount - startCycle), 32'd4);
      waitDrain();

      // Reset in the middle of a multiply drops the operation entirely
      applyStimulus(MUL, 8'h0F, 8'h0F, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(expQ.pop_back());
      @(negedge clk);
      checkOutput("abort out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort in_ready", 32'(in_ready), 32'd1);
      spurious = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      checkOutput("abort no stale result", 32'(spurious), 32'd0);
      @(posedge clk); #1;
      applyStimulus(ADD, 8'h01, 8'h02, 1'b0);
      waitDrain();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
